// File: rtl/ddr_arb_pkg.sv
// ----------------------------------------------------------------------------
// ddr_arb_pkg
// Shared constants and types for the three-requester DDR read-address
// arbiter: requester count, grant/tag widths, outstanding-counter width and
// the two-state issue FSM encoding.
// ----------------------------------------------------------------------------
package ddr_arb_pkg;

    localparam int N_REQ      = 3;                    // number of requesters
    localparam int GRANT_W    = 2;                    // requester index width
    localparam int LOCAL_ID_W = 2;                    // requester-local tag width
    localparam int OUTST_W    = 3;                    // outstanding-burst counter width
    localparam int ID_W       = GRANT_W + LOCAL_ID_W; // DDR-side id width

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/ddr_rd_arb_rr_pick3.sv
// ----------------------------------------------------------------------------
// rr_pick3
// Combinational round-robin picker for three requesters. The search starts
// at (last+1) mod 3 and returns the first eligible requester.
//   eligible[2:0] in  : per-requester eligibility
//   last[1:0]     in  : most recently granted requester
//   hit           out : at least one requester is eligible
//   grant[1:0]    out : selected requester (0 when hit=0)
// ----------------------------------------------------------------------------
module rr_pick3
    import ddr_arb_pkg::*;
(
    input  logic [N_REQ-1:0]   eligible,
    input  logic [GRANT_W-1:0] last,
    output logic               hit,
    output logic [GRANT_W-1:0] grant
);

    logic [GRANT_W-1:0] w_start;
    logic [GRANT_W:0]   w_idx;

    // last=3 never occurs in practice; it is folded onto requester 0 first.
    assign w_start = (last >= GRANT_W'(N_REQ - 1)) ? '0 : last + 1'b1;

    always_comb begin
        hit   = 1'b0;
        grant = '0;
        w_idx = '0;
        for (int off = 0; off < N_REQ; off++) begin
            w_idx = {1'b0, w_start} + (GRANT_W + 1)'(off);
            if (w_idx >= (GRANT_W + 1)'(N_REQ)) begin
                w_idx = w_idx - (GRANT_W + 1)'(N_REQ);
            end
            if (!hit && eligible[w_idx[GRANT_W-1:0]]) begin
                hit   = 1'b1;
                grant = w_idx[GRANT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ddr_rd_arb.sv
// ----------------------------------------------------------------------------
// ddr_rd_arb
// Read-channel arbiter placing three AXI-style read requesters onto one DDR
// controller read channel. Address requests are granted round-robin and
// issued one at a time; read beats are routed back to the requester encoded
// in the upper two bits of the returned id. Each requester is limited to
// MAX_OUTST bursts in flight.
//
// Ports
//   core_clk, resetn          : clock, asynchronous active-low reset
//   ddr_init_done             : grants are held off while low
//   req_ar*  (x3)             : requester address channels, slice i = req i
//   axi_ar*                   : address channel towards the DDR controller
//   axi_r*                    : read data from the DDR controller (no stall)
//   req_r*                    : registered read data to the requesters
//   err                       : one-cycle pulse on bad id or counter underflow
// ----------------------------------------------------------------------------
module ddr_rd_arb
    import ddr_arb_pkg::*;
#(
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int DATA_WIDTH      = 256,
    parameter int MAX_OUTST       = 4
)(
    input  logic                             core_clk,
    input  logic                             resetn,
    input  logic                             ddr_init_done,
    input  logic [N_REQ-1:0]                 req_arvalid,
    output logic [N_REQ-1:0]                 req_arready,
    input  logic [N_REQ*CTRL_ADDR_WIDTH-1:0] req_araddr,
    input  logic [N_REQ*4-1:0]               req_arlen,
    input  logic [N_REQ*LOCAL_ID_W-1:0]      req_arid,
    input  logic [N_REQ-1:0]                 req_aruser_ap,
    output logic                             axi_arvalid,
    input  logic                             axi_arready,
    output logic [CTRL_ADDR_WIDTH-1:0]       axi_araddr,
    output logic [3:0]                       axi_arlen,
    output logic [ID_W-1:0]                  axi_aruser_id,
    output logic                             axi_aruser_ap,
    input  logic                             axi_rvalid,
    input  logic [DATA_WIDTH-1:0]            axi_rdata,
    input  logic [ID_W-1:0]                  axi_rid,
    input  logic                             axi_rlast,
    output logic [N_REQ-1:0]                 req_rvalid,
    output logic [DATA_WIDTH-1:0]            req_rdata,
    output logic [LOCAL_ID_W-1:0]            req_rid,
    output logic                             req_rlast,
    output logic                             err
);

    localparam logic [OUTST_W-1:0] MAX_OUTST_C = OUTST_W'(MAX_OUTST);

    arb_state_t                 r_state;
    arb_state_t                 w_state_nxt;
    logic [GRANT_W-1:0]         r_last_grant;
    logic [GRANT_W-1:0]         r_grantee;
    logic [OUTST_W-1:0]         r_outst [N_REQ];
    logic [CTRL_ADDR_WIDTH-1:0] r_araddr;
    logic [3:0]                 r_arlen;
    logic [LOCAL_ID_W-1:0]      r_arid;
    logic                       r_ap;

    logic [N_REQ-1:0]           r_rvalid;
    logic [DATA_WIDTH-1:0]      r_rdata;
    logic [LOCAL_ID_W-1:0]      r_rid;
    logic                       r_rlast;
    logic                       r_err;

    logic [N_REQ-1:0]           w_elig;
    logic                       w_hit;
    logic [GRANT_W-1:0]         w_pick;
    logic                       w_grant_fire;
    logic                       w_addr_hs;
    logic [N_REQ-1:0]           w_inc;
    logic [N_REQ-1:0]           w_dec;
    logic                       w_underflow;
    logic [GRANT_W-1:0]         w_rk;
    logic                       w_bad_id;
    logic [CTRL_ADDR_WIDTH-1:0] w_sel_addr;
    logic [3:0]                 w_sel_len;
    logic [LOCAL_ID_W-1:0]      w_sel_id;
    logic                       w_sel_ap;

    // ------------------------------------------------------------------
    // Request selection
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_elig[i] = req_arvalid[i] && (r_outst[i] < MAX_OUTST_C);
        end
    end

    rr_pick3 u_pick (
        .eligible (w_elig),
        .last     (r_last_grant),
        .hit      (w_hit),
        .grant    (w_pick)
    );

    always_comb begin
        w_sel_addr = '0;
        w_sel_len  = '0;
        w_sel_id   = '0;
        w_sel_ap   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick == GRANT_W'(i)) begin
                w_sel_addr = req_araddr[i*CTRL_ADDR_WIDTH +: CTRL_ADDR_WIDTH];
                w_sel_len  = req_arlen[i*4 +: 4];
                w_sel_id   = req_arid[i*LOCAL_ID_W +: LOCAL_ID_W];
                w_sel_ap   = req_aruser_ap[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_fire = 1'b0;
        w_addr_hs    = 1'b0;
        case (r_state)
            IDLE: begin
                // req_arready is combinational, so it is also masked by
                // resetn to stay quiet while reset is held.
                if (resetn && ddr_init_done && w_hit) begin
                    w_grant_fire = 1'b1;
                    w_state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                if (axi_arready) begin
                    w_addr_hs   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge core_clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge core_clk or negedge resetn) begin
        if (!resetn) begin
            r_last_grant <= GRANT_W'(N_REQ - 1);
            r_grantee    <= '0;
            r_araddr     <= '0;
            r_arlen      <= '0;
            r_arid       <= '0;
            r_ap         <= 1'b0;
        end else if (w_grant_fire) begin
            r_last_grant <= w_pick;
            r_grantee    <= w_pick;
            r_araddr     <= w_sel_addr;
            r_arlen      <= w_sel_len;
            r_arid       <= w_sel_id;
            r_ap         <= w_sel_ap;
        end
    end

    assign req_arready   = w_grant_fire ? (N_REQ'(1) << w_pick) : '0;
    assign axi_arvalid   = (r_state == ISSUE);
    assign axi_araddr    = r_araddr;
    assign axi_arlen     = r_arlen;
    assign axi_aruser_id = {r_grantee, r_arid};
    assign axi_aruser_ap = r_ap;

    // ------------------------------------------------------------------
    // Outstanding-burst accounting
    // ------------------------------------------------------------------
    assign w_rk     = axi_rid[ID_W-1:LOCAL_ID_W];
    assign w_bad_id = (w_rk == GRANT_W'(N_REQ));

    always_comb begin
        w_underflow = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            w_inc[i] = w_addr_hs && (r_grantee == GRANT_W'(i));
            w_dec[i] = axi_rvalid && axi_rlast && (w_rk == GRANT_W'(i));
            if (w_dec[i] && (r_outst[i] == '0)) begin
                w_underflow = 1'b1;
            end
        end
    end

    // A simultaneous issue and completion on one counter cancel out; a
    // completion against an empty counter leaves it at zero.
    always_ff @(posedge core_clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N_REQ; i++) begin
                r_outst[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_outst[i] <= r_outst[i] + 1'b1;
                end else if (w_dec[i] && !w_inc[i] && (r_outst[i] != '0)) begin
                    r_outst[i] <= r_outst[i] - 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read-data return path (one register stage)
    // ------------------------------------------------------------------
    always_ff @(posedge core_clk or negedge resetn) begin
        if (!resetn) begin
            r_rvalid <= '0;
            r_rdata  <= '0;
            r_rid    <= '0;
            r_rlast  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= (axi_rvalid && !w_bad_id) ? (N_REQ'(1) << w_rk) : '0;
            r_rlast  <= axi_rvalid && axi_rlast && !w_bad_id;
            r_err    <= (axi_rvalid && w_bad_id) || w_underflow;
            if (axi_rvalid) begin
                r_rdata <= axi_rdata;
                r_rid   <= axi_rid[LOCAL_ID_W-1:0];
            end
        end
    end

    assign req_rvalid = r_rvalid;
    assign req_rdata  = r_rdata;
    assign req_rid    = r_rid;
    assign req_rlast  = r_rlast;
    assign err        = r_err;

endmodule

// File: tb/tb_ddr_rd_arb.sv
module tb_ddr_rd_arb;

    localparam int AW = 28;
    localparam int DW = 256;
    localparam int MO = 4;

    logic            core_clk = 1'b0;
    logic            resetn;
    logic            ddr_init_done;
    logic [2:0]      req_arvalid;
    logic [2:0]      req_arready;
    logic [3*AW-1:0] req_araddr;
    logic [11:0]     req_arlen;
    logic [5:0]      req_arid;
    logic [2:0]      req_aruser_ap;
    logic            axi_arvalid;
    logic            axi_arready;
    logic [AW-1:0]   axi_araddr;
    logic [3:0]      axi_arlen;
    logic [3:0]      axi_aruser_id;
    logic            axi_aruser_ap;
    logic            axi_rvalid;
    logic [DW-1:0]   axi_rdata;
    logic [3:0]      axi_rid;
    logic            axi_rlast;
    logic [2:0]      req_rvalid;
    logic [DW-1:0]   req_rdata;
    logic [1:0]      req_rid;
    logic            req_rlast;
    logic            err;

    always #5 core_clk = ~core_clk;

    ddr_rd_arb #(.CTRL_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTST(MO)) dut (
        .core_clk      (core_clk),
        .resetn        (resetn),
        .ddr_init_done (ddr_init_done),
        .req_arvalid   (req_arvalid),
        .req_arready   (req_arready),
        .req_araddr    (req_araddr),
        .req_arlen     (req_arlen),
        .req_arid      (req_arid),
        .req_aruser_ap (req_aruser_ap),
        .axi_arvalid   (axi_arvalid),
        .axi_arready   (axi_arready),
        .axi_araddr    (axi_araddr),
        .axi_arlen     (axi_arlen),
        .axi_aruser_id (axi_aruser_id),
        .axi_aruser_ap (axi_aruser_ap),
        .axi_rvalid    (axi_rvalid),
        .axi_rdata     (axi_rdata),
        .axi_rid       (axi_rid),
        .axi_rlast     (axi_rlast),
        .req_rvalid    (req_rvalid),
        .req_rdata     (req_rdata),
        .req_rid       (req_rid),
        .req_rlast     (req_rlast),
        .err           (err)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_arvalid   = '0;
        req_araddr    = '0;
        req_arlen     = '0;
        req_arid      = '0;
        req_aruser_ap = '0;
        axi_arready   = 1'b0;
        axi_rvalid    = 1'b0;
        axi_rdata     = '0;
        axi_rid       = '0;
        axi_rlast     = 1'b0;
    endtask

    task automatic do_reset();
        resetn        = 1'b0;
        ddr_init_done = 1'b0;
        idle_inputs();
        repeat (2) @(posedge core_clk);
        #1 resetn = 1'b1;
    endtask

    // Round-robin choice from the rule: first eligible at last+1, last+2, last+3 (mod 3).
    function automatic int rr_ref(input logic [2:0] el, input int last);
        for (int o = 1; o <= 3; o++) begin
            int c;
            c = (last + o) % 3;
            if (el[c]) return c;
        end
        return -1;
    endfunction

    typedef struct {
        logic       rv;
        logic [3:0] rid;
        logic       rl;
        logic [7:0] bt;
        logic [2:0] exp_rv;
        logic [1:0] exp_rid;
        logic       exp_err;
    } rvec_t;

    rvec_t tbl [7];

    // Reference model state
    bit            m_busy;
    int            m_g, m_last;
    int            m_outst [3];
    logic [AW-1:0] m_addr;
    logic [3:0]    m_len;
    logic [1:0]    m_id;
    logic          m_ap;
    logic [2:0]    m_rv;
    logic [1:0]    m_rid;
    logic [DW-1:0] m_rdata;
    logic          m_err;

    initial begin
        int gq[$];
        int gc[$];
        logic [DW-1:0] wide;

        // ---------------- reset state ----------------
        resetn        = 1'b0;
        idle_inputs();
        ddr_init_done = 1'b1;
        req_arvalid   = 3'b111;
        axi_arready   = 1'b1;
        axi_rvalid    = 1'b1;
        axi_rid       = 4'b0001;
        axi_rlast     = 1'b1;
        #22;
        chk("rst_arready",  req_arready,   3'b000);
        chk("rst_arvalid",  axi_arvalid,   1'b0);
        chk("rst_araddr",   axi_araddr,    '0);
        chk("rst_userid",   axi_aruser_id, 4'h0);
        chk("rst_rvalid",   req_rvalid,    3'b000);
        chk("rst_rdata",    req_rdata,     '0);
        chk("rst_rlast",    req_rlast,     1'b0);
        chk("rst_err",      err,           1'b0);

        // ---------------- grant order 0,1,2,0 ----------------
        do_reset();
        ddr_init_done = 1'b1;
        req_arvalid   = 3'b111;
        axi_arready   = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            for (int i = 0; i < 3; i++) begin
                if (req_arready[i]) begin
                    gq.push_back(i);
                    gc.push_back(c);
                end
            end
            tick();
        end
        chk("rr_count", gq.size(), 4);
        if (gq.size() == 4) begin
            chk("rr_g0", gq[0], 0);
            chk("rr_g1", gq[1], 1);
            chk("rr_g2", gq[2], 2);
            chk("rr_g3", gq[3], 0);
            for (int i = 1; i < 4; i++) chk("rr_spacing", gc[i] - gc[i-1], 2);
        end

        // ---------------- table: read-beat routing ----------------
        tbl[0] = '{1'b1, 4'b1011, 1'b0, 8'hA5, 3'b100, 2'd3, 1'b0};
        tbl[1] = '{1'b1, 4'b1100, 1'b0, 8'h3C, 3'b000, 2'd0, 1'b1};
        tbl[2] = '{1'b1, 4'b0001, 1'b0, 8'h11, 3'b001, 2'd1, 1'b0};
        tbl[3] = '{1'b1, 4'b0110, 1'b0, 8'h22, 3'b010, 2'd2, 1'b0};
        tbl[4] = '{1'b0, 4'b0100, 1'b0, 8'h33, 3'b000, 2'd0, 1'b0};
        tbl[5] = '{1'b1, 4'b0000, 1'b1, 8'h44, 3'b001, 2'd0, 1'b1};
        tbl[6] = '{1'b1, 4'b1111, 1'b1, 8'h55, 3'b000, 2'd0, 1'b1};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            axi_rvalid = tbl[i].rv;
            axi_rid    = tbl[i].rid;
            axi_rlast  = tbl[i].rl;
            axi_rdata  = {32{tbl[i].bt}};
            tick();
            chk("tbl_rvalid", req_rvalid, tbl[i].exp_rv);
            chk("tbl_err",    err,        tbl[i].exp_err);
            if (tbl[i].exp_rv != 3'b000) begin
                chk("tbl_rid",   req_rid,   tbl[i].exp_rid);
                chk("tbl_rdata", req_rdata, {32{tbl[i].bt}});
            end
        end
        idle_inputs();
        tick();
        chk("tbl_rvalid_clr", req_rvalid, 3'b000);
        chk("tbl_err_pulse",  err,        1'b0);

        // ---------------- req1 only, held until arready ----------------
        do_reset();
        ddr_init_done          = 1'b1;
        req_arvalid            = 3'b010;
        req_araddr[AW +: AW]   = 28'h0001000;
        req_arlen[4 +: 4]      = 4'd7;
        req_arid[2 +: 2]       = 2'd2;
        req_aruser_ap          = 3'b010;
        #1;
        chk("r1_arready", req_arready, 3'b010);
        tick();
        req_arvalid = 3'b000;
        req_araddr  = '1;
        #1;
        chk("r1_arvalid", axi_arvalid,   1'b1);
        chk("r1_araddr",  axi_araddr,    28'h0001000);
        chk("r1_arlen",   axi_arlen,     4'd7);
        chk("r1_userid",  axi_aruser_id, 4'b0110);
        chk("r1_ap",      axi_aruser_ap, 1'b1);
        tick();
        tick();
        chk("r1_hold_valid", axi_arvalid, 1'b1);
        chk("r1_hold_addr",  axi_araddr,  28'h0001000);
        axi_arready = 1'b1;
        tick();
        axi_arready = 1'b0;
        chk("r1_done_valid", axi_arvalid, 1'b0);

        // ---------------- req0 ineligible at MAX_OUTST ----------------
        do_reset();
        ddr_init_done = 1'b1;
        axi_arready   = 1'b1;
        req_arvalid   = 3'b001;
        repeat (8) tick();
        req_arvalid = 3'b101;
        #1;
        chk("full_grant2a", req_arready, 3'b100);
        tick();
        tick();
        req_arvalid = 3'b001;
        #1;
        chk("full_req0_blocked", req_arready, 3'b000);
        req_arvalid = 3'b101;
        #1;
        chk("full_grant2b", req_arready, 3'b100);
        tick();
        req_arvalid = 3'b001;
        axi_rvalid  = 1'b1;
        axi_rid     = 4'b0001;
        axi_rlast   = 1'b1;
        tick();
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
        #1;
        chk("full_beat_rvalid", req_rvalid,  3'b001);
        chk("full_beat_rlast",  req_rlast,   1'b1);
        chk("full_beat_err",    err,         1'b0);
        chk("full_reenabled",   req_arready, 3'b001);

        // ---------------- handshake coinciding with rlast ----------------
        do_reset();
        ddr_init_done = 1'b1;
        axi_arready   = 1'b1;
        req_arvalid   = 3'b001;
        repeat (7) tick();
        axi_rvalid = 1'b1;
        axi_rid    = 4'b0001;
        axi_rlast  = 1'b1;
        tick();
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
        #1;
        chk("coin_err",     err,         1'b0);
        chk("coin_elig",    req_arready, 3'b001);
        tick();
        tick();
        chk("coin_full",    req_arready, 3'b000);

        // ---------------- reset while issuing ----------------
        do_reset();
        ddr_init_done = 1'b1;
        req_arvalid   = 3'b010;
        #1;
        chk("ri_arready", req_arready, 3'b010);
        tick();
        chk("ri_issuing", axi_arvalid, 1'b1);
        #2 resetn = 1'b0;
        #1;
        chk("ri_async_arvalid", axi_arvalid,   1'b0);
        chk("ri_async_userid",  axi_aruser_id, 4'h0);
        @(posedge core_clk);
        tick();
        resetn      = 1'b1;
        req_arvalid = 3'b111;
        #1;
        chk("ri_first_grant", req_arready, 3'b001);

        // ---------------- randomized run against reference model ----------------
        do_reset();
        m_busy = 0; m_g = 0; m_last = 2;
        for (int i = 0; i < 3; i++) m_outst[i] = 0;
        m_addr = '0; m_len = '0; m_id = '0; m_ap = 1'b0;
        m_rv = '0; m_rid = '0; m_rdata = '0; m_err = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            int g, k;
            logic [2:0] el;
            logic n_err;
            // registered outputs against model
            chk("rnd_rvalid", req_rvalid, m_rv);
            chk("rnd_err",    err,        m_err);
            if (m_rv != 3'b000) begin
                chk("rnd_rid",   req_rid,   m_rid);
                chk("rnd_rdata", req_rdata, m_rdata);
            end
            // new stimulus
            ddr_init_done = ($urandom_range(0, 9) != 0);
            req_arvalid   = 3'($urandom_range(0, 7));
            for (int i = 0; i < 3; i++) req_araddr[i*AW +: AW] = AW'($urandom);
            req_arlen     = 12'($urandom);
            req_arid      = 6'($urandom);
            req_aruser_ap = 3'($urandom);
            axi_arready   = ($urandom_range(0, 1) == 1);
            axi_rvalid    = ($urandom_range(0, 2) != 0);
            k             = $urandom_range(0, 9);
            k             = (k == 9) ? 3 : k % 3;
            axi_rid       = {2'(k), 2'($urandom)};
            axi_rlast     = ($urandom_range(0, 4) < 2);
            for (int w = 0; w < DW / 32; w++) wide[w*32 +: 32] = $urandom;
            axi_rdata     = wide;
            #1;
            // combinational outputs
            for (int i = 0; i < 3; i++) el[i] = req_arvalid[i] && (m_outst[i] < MO);
            g = (!m_busy && ddr_init_done) ? rr_ref(el, m_last) : -1;
            chk("rnd_arready", req_arready, (g >= 0) ? (3'b001 << g) : 3'b000);
            chk("rnd_arvalid", axi_arvalid, m_busy);
            if (m_busy) begin
                chk("rnd_araddr", axi_araddr,    m_addr);
                chk("rnd_arlen",  axi_arlen,     m_len);
                chk("rnd_userid", axi_aruser_id, {2'(m_g), m_id});
                chk("rnd_ap",     axi_aruser_ap, m_ap);
            end
            // model advance
            n_err = axi_rvalid && ((k == 3) || (axi_rlast && m_outst[k] == 0));
            for (int i = 0; i < 3; i++) begin
                bit inc, dec;
                inc = m_busy && axi_arready && (m_g == i);
                dec = axi_rvalid && axi_rlast && (k == i);
                if (inc && !dec) m_outst[i]++;
                else if (dec && !inc && m_outst[i] > 0) m_outst[i]--;
            end
            if (m_busy) begin
                if (axi_arready) m_busy = 0;
            end else if (g >= 0) begin
                m_busy = 1;
                m_g    = g;
                m_last = g;
                m_addr = req_araddr[g*AW +: AW];
                m_len  = req_arlen[g*4 +: 4];
                m_id   = req_arid[g*2 +: 2];
                m_ap   = req_aruser_ap[g];
            end
            m_rv  = (axi_rvalid && k < 3) ? (3'b001 << k) : 3'b000;
            m_err = n_err;
            if (axi_rvalid) begin
                m_rdata = axi_rdata;
                m_rid   = axi_rid[1:0];
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
